mips_div_seq: RTL and testbench

Iterative restoring divider that produces the MIPS DIV/DIVU results (quotient to LO, remainder to HI) one bit per cycle. It is the inverse of the ripple/lookahead add path: each iteration performs one trial subtraction and restores on borrow. It sits beside the combinational ALU in the execute stage. It is driven by a start/busy/done handshake so the pipeline can stall on HI/LO reads until the result is ready.

---
 rtl/mips_div_pkg.sv | 20 ++
 rtl/mips_div_step.sv | 38 +++
 rtl/mips_div_seq.sv | 176 +++++++++++++++++
 tb/tb_mips_div_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS DIV/DIVU sequential divider.
// Provides the FSM state enum, the default operand width and the
// iteration-counter width helper.
package mips_div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Bits needed to count iterations 0..w-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_i  partial remainder (WIDTH bits, always below the divisor)
//   quo_i  quotient shift register; its MSB is the next dividend bit
//   dvs_i  divisor magnitude
//   rem_o  next partial remainder
//   quo_o  next quotient shift register (new quotient bit in LSB)
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted_c;
  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;

  // Shift in the next dividend bit, then trial-subtract; restore on borrow.
  // When no borrow occurs the true difference is below the divisor, so the
  // low WIDTH bits of the subtraction are exact.
  always_comb begin
    shifted_c = {rem_i, quo_i[WIDTH-1]};
    borrow_c  = (shifted_c < {1'b0, dvs_i});
    diff_c    = shifted_c[WIDTH-1:0] - dvs_i;
    if (borrow_c) begin
      rem_o = shifted_c[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff_c;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_div_seq.sv
// Iterative restoring divider producing MIPS DIV/DIVU results
// (quotient -> LO, remainder -> HI), one quotient bit per cycle.
// Optional feature macro: MIPS_DIV_SIGNED_EN (adds is_signed and signed
// magnitude conversion / result negation; otherwise always DIVU).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request, sampled only in IDLE
//   dividend, divisor   operands, sampled with start
//   is_signed           1 = DIV, 0 = DIVU (MIPS_DIV_SIGNED_EN only)
//   busy                high from accept until the done cycle
//   done                one-cycle result-valid pulse
//   quotient, remainder results, held until the next result load
//   div_by_zero         divisor was zero for the held result
module mips_div_seq
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef MIPS_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
`ifdef MIPS_DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [WIDTH-1:0] step_rem_c;
  logic [WIDTH-1:0] step_quo_c;

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_c),
    .quo_o (step_quo_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      zero_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef MIPS_DIV_SIGNED_EN
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      zero_q        <= zero_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef MIPS_DIV_SIGNED_EN
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
`endif
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    zero_d        = zero_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
`ifdef MIPS_DIV_SIGNED_EN
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = dividend;
          dvs_d   = divisor;
          zero_d  = (divisor == '0);
`ifdef MIPS_DIV_SIGNED_EN
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          if (is_signed) begin
            quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_d     = divisor[WIDTH-1]  ? -divisor  : divisor;
            // A zero divisor must leave the all-ones quotient untouched.
            neg_quo_d = (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
            neg_rem_d = dividend[WIDTH-1];
          end
`endif
        end
      end
      S_RUN: begin
        rem_d = step_rem_c;
        quo_d = step_quo_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
`ifdef MIPS_DIV_SIGNED_EN
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
`else
        quotient_d  = quo_q;
        remainder_d = rem_q;
`endif
        div_by_zero_d = zero_q;
        state_d       = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mips_div_seq.sv
// Directed self-checking bench for mips_div_seq (WIDTH=32).
// Signed vectors are exercised when MIPS_DIV_SIGNED_EN is defined.
module tb_mips_div_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef MIPS_DIV_SIGNED_EN
  logic         is_signed;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_err    = 0;

  mips_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef MIPS_DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge of the first RUN cycle.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
`ifdef MIPS_DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

`ifdef MIPS_DIV_SIGNED_EN
  task automatic issue_s(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    start     = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    is_signed = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    is_signed = 1'b0;
  endtask
`endif

  // Wait (bounded) for done; lat counts cycles since the accept cycle.
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full operation: issue, wait, check latency and results.
  task automatic div_check(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic sgn, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_z);
    int lat;
`ifdef MIPS_DIV_SIGNED_EN
    if (sgn) issue_s(dvd, dvs);
    else     issue(dvd, dvs);
`else
    if (!sgn) issue(dvd, dvs);
`endif
    wait_done(1, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd34);
    check_eq({tag, "_q"}, quotient, exp_q);
    check_eq({tag, "_r"}, remainder, exp_r);
    check_eq({tag, "_z"}, 32'(div_by_zero), 32'(exp_z));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef MIPS_DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_q", quotient, 32'd0);
    check_eq("rst_r", remainder, 32'd0);
    check_eq("rst_z", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned directed vectors.
    div_check("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    div_check("u_dbz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    div_check("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    div_check("u_8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
    div_check("u_eq", 32'd1000, 32'd1000, 1'b0, 32'd1, 32'd0, 1'b0);
    div_check("u_small", 32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0);
    div_check("u_big", 32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0);

    // Starts during RUN and in the DONE cycle are ignored.
    issue(32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    check_eq("ign_busy_run", 32'(busy), 32'd1);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, lat);
    check_eq("ign_lat", 32'(lat), 32'd34);
    check_eq("ign_q", quotient, 32'd142);
    check_eq("ign_r", remainder, 32'd6);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check_eq("ign_done_start_busy", 32'(busy), 32'd0);
    check_eq("ign_done_start_q", quotient, 32'd142);
    // Accepted in the first IDLE cycle after DONE.
    issue(32'd9, 32'd3);
    check_eq("acc_busy", 32'(busy), 32'd1);
    wait_done(1, lat);
    check_eq("acc_lat", 32'(lat), 32'd34);
    check_eq("acc_q", quotient, 32'd3);
    check_eq("acc_r", remainder, 32'd0);
    @(negedge clk);

    // Reset at iteration 10 aborts with no done pulse.
    issue(32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_q", quotient, 32'd0);
    check_eq("mid_rst_r", remainder, 32'd0);
    check_eq("mid_rst_z", 32'(div_by_zero), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("mid_rst_no_done", 32'(pulses), 32'd0);
    div_check("post_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

`ifdef MIPS_DIV_SIGNED_EN
    div_check("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    div_check("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    div_check("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    div_check("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    div_check("s_m_m", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
    div_check("s_dbz", 32'h8765_4321, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
